// File: rtl/mul_seq_combine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_seq_combine: sequences a 32x32 multiply over a 3-lane 16x16 cell and |
// | combines partial products into the low or high result word.              |
// | Optional: MUL_SEQ_SIGNED_EN adds signed high-word correction.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mul_seq_combine #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              start_ready,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              flush,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [DATA_W-1:0] cell_src1,
   output logic [DATA_W-1:0] cell_src2,
   output logic              cell_en,
   input  logic [DATA_W-1:0] cell_p1,
   input  logic [DATA_W-1:0] cell_p2,
   input  logic [DATA_W-1:0] cell_p3
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE1 = 3'd1,
      S_WAIT1  = 3'd2,
      S_ISSUE2 = 3'd3,
      S_WAIT2  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [1:0]        r_op;
   logic [31:0]       r_p_ll;
   logic [31:0]       r_p_lh;
   logic [31:0]       r_p_hl;
   logic [DATA_W-1:0] r_result;

   logic              w_in_wait1;
   logic [31:0]       w_ll;
   logic [31:0]       w_lh;
   logic [31:0]       w_hl;
   logic [32:0]       w_mid;
   logic [32:0]       w_lo_sum;
   logic [31:0]       w_hi_u;
   logic [31:0]       w_hi;

   // In WAIT1 the low word is formed straight from the cell outputs; in WAIT2
   // the cell carries hi*hi, so the first-pass products come from registers.
   assign w_in_wait1 = (r_state == S_WAIT1);
   assign w_ll       = w_in_wait1 ? cell_p1 : r_p_ll;
   assign w_lh       = w_in_wait1 ? cell_p2 : r_p_lh;
   assign w_hl       = w_in_wait1 ? cell_p3 : r_p_hl;
   assign w_mid      = {1'b0, w_lh} + {1'b0, w_hl};
   assign w_lo_sum   = {1'b0, w_ll} + {1'b0, w_mid[15:0], 16'h0};
   assign w_hi_u     = cell_p1 + {15'h0, w_mid[32:16]} + {31'h0, w_lo_sum[32]};

`ifdef MUL_SEQ_SIGNED_EN
   always_comb begin
      w_hi = w_hi_u;
      if (r_op == 2'b10)
         w_hi = w_hi_u - (r_a[31] ? r_b : '0) - (r_b[31] ? r_a : '0);
      else if (r_op == 2'b11)
         w_hi = w_hi_u - (r_a[31] ? r_b : '0);
   end
`else
   assign w_hi = w_hi_u;
`endif

   always_comb begin
      w_next_state = r_state;
      start_ready  = 1'b0;
      result_valid = 1'b0;
      cell_en      = 1'b0;
      cell_src1    = '0;
      cell_src2    = '0;
      case (r_state)
         S_IDLE: begin
            start_ready = 1'b1;
            if (start) w_next_state = S_ISSUE1;
         end
         S_ISSUE1: begin
            cell_en      = 1'b1;
            cell_src1    = r_a;
            cell_src2    = r_b;
            w_next_state = S_WAIT1;
         end
         S_WAIT1:  w_next_state = (r_op == 2'b00) ? S_DONE : S_ISSUE2;
         S_ISSUE2: begin
            cell_en      = 1'b1;
            cell_src1    = {16'h0, r_a[31:16]};
            cell_src2    = {16'h0, r_b[31:16]};
            w_next_state = S_WAIT2;
         end
         S_WAIT2:  w_next_state = S_DONE;
         S_DONE: begin
            result_valid = 1'b1;
            if (result_ready) w_next_state = S_IDLE;
         end
         default:  w_next_state = S_IDLE;
      endcase
      if (flush && (r_state != S_IDLE)) w_next_state = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= 2'b00;
         r_p_ll   <= '0;
         r_p_lh   <= '0;
         r_p_hl   <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_next_state;
         if ((r_state == S_IDLE) && start) begin
            r_a  <= src_a;
            r_b  <= src_b;
            r_op <= op;
         end
         if (!flush) begin
            if (r_state == S_WAIT1) begin
               r_p_ll <= cell_p1;
               r_p_lh <= cell_p2;
               r_p_hl <= cell_p3;
               if (r_op == 2'b00) r_result <= w_lo_sum[31:0];
            end
            if (r_state == S_WAIT2) r_result <= w_hi;
         end
      end
   end

   assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_combine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mul_seq_combine: self-checking bench with a behavioural cell model    |
// | and a 64-bit arithmetic reference for the product words.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mul_seq_combine;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        start_ready;
   logic [1:0]  tb_op = 2'b00;
   logic [31:0] tb_a = '0;
   logic [31:0] tb_b = '0;
   logic        flush = 1'b0;
   logic [31:0] result;
   logic        result_valid;
   logic        result_ready = 1'b0;
   logic [31:0] cell_src1;
   logic [31:0] cell_src2;
   logic        cell_en;
   logic [31:0] m_p1 = '0;
   logic [31:0] m_p2 = '0;
   logic [31:0] m_p3 = '0;

   int checks = 0;
   int failures = 0;

   mul_seq_combine #(.DATA_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .start_ready(start_ready),
      .op(tb_op), .src_a(tb_a), .src_b(tb_b), .flush(flush),
      .result(result), .result_valid(result_valid), .result_ready(result_ready),
      .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
      .cell_p1(m_p1), .cell_p2(m_p2), .cell_p3(m_p3)
   );

   always #5 clk = ~clk;

   // Registered three-lane 16x16 cell; outputs hold while cell_en is low.
   always @(posedge clk) begin
      if (cell_en) begin
         m_p1 <= 32'(cell_src1[15:0])  * 32'(cell_src2[15:0]);
         m_p2 <= 32'(cell_src1[15:0])  * 32'(cell_src2[31:16]);
         m_p3 <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
      end
   end

   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] xa;
      logic [63:0] xb;
      logic [63:0] p;
      xa = {32'h0, a};
      xb = {32'h0, b};
`ifdef MUL_SEQ_SIGNED_EN
      if (o == 2'b10 || o == 2'b11) xa = {{32{a[31]}}, a};
      if (o == 2'b10)               xb = {{32{b[31]}}, b};
`endif
      p = xa * xb;
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Drives one request and returns what was observed; lat is -1 on timeout.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic flush_at_accept, output logic [31:0] res,
                         output int lat, output int mask, output logic idle_after);
      int n;
      res = '0; lat = -1; mask = 0; idle_after = 1'b0;
      @(negedge clk);
      start = 1'b1; tb_op = o; tb_a = a; tb_b = b; flush = flush_at_accept;
      @(negedge clk);
      start = 1'b0; flush = 1'b0; n = 1;
      while (n < 20 && !result_valid) begin
         if (cell_en) mask |= (1 << n);
         @(negedge clk);
         n++;
      end
      if (result_valid) begin
         lat = n;
         res = result;
         result_ready = 1'b1;
         @(negedge clk);
         result_ready = 1'b0;
         idle_after = start_ready;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (result !== 32'h0 || result_valid !== 1'b0 || cell_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: result=%h valid=%b en=%b, required 0/0/0",
                  result, result_valid, cell_en);
      end
      checks++;
      if (cell_src1 !== 32'h0 || cell_src2 !== 32'h0 || start_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: src1=%h src2=%h ready=%b, required 0/0/1",
                  cell_src1, cell_src2, start_ready);
      end
   endtask

   task automatic test_directed;
      logic [31:0] res;
      logic [31:0] exp_ss;
      int lat, mask;
      logic idle;
      run_op(2'b00, 32'h00010003, 32'h00020005, 1'b0, res, lat, mask, idle);
      checks++;
      if (res !== 32'h000B000F || lat != 3 || mask != 'b10 || idle !== 1'b1) begin
         failures++;
         $display("FAIL mul_basic: res=%h lat=%0d enmask=%b idle=%b, required 000b000f/3/10/1",
                  res, lat, mask, idle);
      end
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, res, lat, mask, idle);
      checks++;
      if (res !== 32'hFFFFFFFE || lat != 5 || mask != 'b1010) begin
         failures++;
         $display("FAIL mulxuu_max: res=%h lat=%0d enmask=%b, required fffffffe/5/1010",
                  res, lat, mask);
      end
`ifdef MUL_SEQ_SIGNED_EN
      exp_ss = 32'h00000000;
`else
      exp_ss = 32'hFFFFFFFE;
`endif
      run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, res, lat, mask, idle);
      checks++;
      if (res !== exp_ss || lat != 5) begin
         failures++;
         $display("FAIL mulxss_m1: res=%h lat=%0d, required %h/5", res, lat, exp_ss);
      end
   endtask

   task automatic test_backpressure;
      int n;
      @(negedge clk);
      start = 1'b1; tb_op = 2'b00; tb_a = 32'd7; tb_b = 32'd6;
      @(negedge clk);
      start = 1'b0; n = 1;
      while (n < 20 && !result_valid) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 3) begin
         failures++;
         $display("FAIL bp_latency: got %0d cycles, required 3", n);
      end
      for (int i = 0; i < 4; i++) begin
         start = 1'b1; tb_op = 2'($urandom); tb_a = $urandom; tb_b = $urandom;
         @(negedge clk);
         checks++;
         if (result !== 32'h2A || result_valid !== 1'b1 || start_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold%0d: result=%h valid=%b ready=%b, required 0000002a/1/0",
                     i, result, result_valid, start_ready);
         end
      end
      start = 1'b0;
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      checks++;
      if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release: ready=%b valid=%b, required 1/0", start_ready, result_valid);
      end
   endtask

   task automatic test_flush;
      logic [31:0] res;
      int lat, mask;
      logic idle;
      int seen;
      @(negedge clk);
      start = 1'b1; tb_op = 2'b01; tb_a = $urandom; tb_b = $urandom;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (start_ready !== 1'b1 || result_valid !== 1'b0 || cell_en !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle: ready=%b valid=%b en=%b, required 1/0/0",
                  start_ready, result_valid, cell_en);
      end
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (result_valid === 1'b1 || cell_en === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL flush_quiet: activity in %0d cycles, required 0", seen);
      end
      run_op(2'b00, 32'd3, 32'd5, 1'b0, res, lat, mask, idle);
      checks++;
      if (res !== 32'h0000000F || lat != 3) begin
         failures++;
         $display("FAIL flush_next: res=%h lat=%0d, required 0000000f/3", res, lat);
      end
      run_op(2'b00, 32'd7, 32'd9, 1'b1, res, lat, mask, idle);
      checks++;
      if (res !== 32'd63 || lat != 3) begin
         failures++;
         $display("FAIL flush_in_idle: res=%h lat=%0d, required 0000003f/3", res, lat);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] a;
      a = 32'h1234_5678;
      @(negedge clk);
      start = 1'b1; tb_op = 2'b01; tb_a = a; tb_b = 32'h9ABC_DEF0;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (cell_en !== 1'b1 || cell_src1 !== {16'h0, a[31:16]}) begin
         failures++;
         $display("FAIL issue2_drive: en=%b src1=%h, required 1/%h", cell_en, cell_src1,
                  {16'h0, a[31:16]});
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (result !== 32'h0 || result_valid !== 1'b0 || cell_en !== 1'b0 || start_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid: result=%h valid=%b en=%b ready=%b, required 0/0/0/1",
                  result, result_valid, cell_en, start_ready);
      end
   endtask

   task automatic test_random;
      logic [31:0] res, a, b, exp;
      logic [1:0]  o;
      int lat, mask;
      logic idle;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0:       a = 32'h8000_0000;
            1:       a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       b = 32'h0;
            1:       b = 32'h8000_0001;
            default: b = $urandom;
         endcase
         exp = ref_result(o, a, b);
         run_op(o, a, b, 1'b0, res, lat, mask, idle);
         checks++;
         if (res !== exp) begin
            failures++;
            $display("FAIL rand_result op=%b a=%h b=%h: got %h, required %h", o, a, b, res, exp);
         end
         checks++;
         if (lat != ((o == 2'b00) ? 3 : 5) || mask != ((o == 2'b00) ? 'b10 : 'b1010)) begin
            failures++;
            $display("FAIL rand_timing op=%b: lat=%0d enmask=%b, required %0d/%b", o, lat, mask,
                     (o == 2'b00) ? 3 : 5, (o == 2'b00) ? 2'b10 : 4'b1010);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mul_seq_combine.md
Name: mul_seq_combine

Overview:
- Multiply sequencer and partial-product combiner for the CPU's hardware multiplier.
- Accepts a 32x32 multiply request and drives operand halves into the three-lane 16x16 multiplier cell. The cell produces registered unsigned products lo*lo, lo*hi and hi*lo.
- Captures the partial products and returns the low word (MUL) or high word (MULX*) of the 64-bit product.
- For MULX*, a second cell pass computes hi*hi.

Parameters:
- DATA_W, 32, operand/result width; only 32 supported (cell lanes fixed at 16 bits).

Ports:
- clk  in  1  clock; shared with the multiplier cell.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request valid.
- start_ready  out  1  high only in IDLE; request accepted when start && start_ready.
- op  in  2  00 MUL (low word), 01 MULXUU, 10 MULXSS, 11 MULXSU (high word).
- src_a  in  32  operand A, sampled at accept.
- src_b  in  32  operand B, sampled at accept.
- flush  in  1  abort in-flight op.
- result  out  32  product word.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- cell_src1  out  32  to cell E_src1.
- cell_src2  out  32  to cell E_src2.
- cell_en  out  1  to cell M_en.
- cell_p1  in  32  lo*lo.
- cell_p2  in  32  a_lo*b_hi.
- cell_p3  in  32  a_hi*b_lo.

Behaviour:
- Reset (synchronous, active-high): state IDLE; result=0, result_valid=0, cell_en=0, cell_src1=0, cell_src2=0; start_ready=1 from the first cycle after reset.
- FSM states: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE.
- IDLE: on start, latch src_a, src_b and op into a_r, b_r, op_r; go to ISSUE1.
- ISSUE1: cell_src1=a_r, cell_src2=b_r, cell_en=1; go to WAIT1.
- WAIT1: cell outputs are valid.
  - Capture p_ll=cell_p1, p_lh=cell_p2, p_hl=cell_p3.
  - op_r==00: load result with the low word; go to DONE.
  - Otherwise: go to ISSUE2.
- ISSUE2: cell_src1={16'h0,a_r[31:16]}, cell_src2={16'h0,b_r[31:16]}, cell_en=1; go to WAIT2.
- WAIT2: p_hh=cell_p1; load result with the high word; go to DONE.
- DONE: result_valid=1; result held stable until result_ready, then go to IDLE. A new start is accepted no earlier than the following cycle.
- cell_en is 0 in every state except ISSUE1 and ISSUE2. The cell output therefore holds between passes.
- cell_src1/cell_src2 are 0 outside the ISSUE states.
- Arithmetic:
  - mid = p_lh + p_hl (33 bit).
  - lo_sum = p_ll + {mid[15:0],16'h0} (33 bit).
  - low word = lo_sum[31:0].
  - high word = p_hh + mid[32:16] + lo_sum[32], mod 2^32.
- Latency from accept cycle T: result_valid rises at T+3 for MUL and T+5 for MULX*.
- flush in any non-IDLE state returns the FSM to IDLE next cycle. result_valid=0 and no result is produced. flush takes priority over result_ready and state advance. flush in IDLE is ignored; a start in the same cycle is still accepted.
- start while not IDLE is ignored (start_ready=0). Operands are not re-sampled.
- Reset mid-operation behaves as flush and additionally zeroes result.

Optional Feature:
- Macro: MUL_SEQ_SIGNED_EN.
- Defined: high word gets a signed correction.
  - MULXSS subtracts (a_r[31]?b_r:0) and (b_r[31]?a_r:0).
  - MULXSU subtracts (a_r[31]?b_r:0).
  - Correction is applied in WAIT2, same latency.
- Undefined: ops 10 and 11 compute the same value as MULXUU.

Test Plan:
- MUL a=0x00010003, b=0x00020005 -> result=0x000B000F; result_valid at T+3; cell_en high exactly one cycle.
- MULXUU a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE at T+5; cell_en high in two non-adjacent cycles.
- MULXSS a=0xFFFFFFFF, b=0xFFFFFFFF -> with MUL_SEQ_SIGNED_EN: 0x00000000; without: 0xFFFFFFFE.
- Backpressure: MUL 7*6 with result_ready=0 for 4 cycles -> result=0x0000002A held and valid; start pulses ignored (start_ready=0); IDLE the cycle after ready.
- flush asserted in WAIT1 of a MULXUU -> no result_valid; IDLE next cycle; following MUL 3*5 returns 0x0000000F.
- reset asserted in ISSUE2 -> next cycle result=0, result_valid=0, cell_en=0, start_ready=1.
